// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32I decode encodings and ID/EX control bundle
//
// Contents:
//   OP_*        opcode values
//   imm_src_e   immediate format select (I=00, S=01, B=10, J=11)
//   alu_ctrl_e  ALU operation encoding seen by execute
//   result_src_e write-back source select
//   ctrl_t      packed control bundle carried through ID/EX
//   imm_extend  sign-extends the immediate of a given format
package riscv_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    logic        jump;
    logic        branch;
    alu_ctrl_e   alu_control;
    logic        alu_src;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  function automatic logic [31:0] imm_extend(input logic [31:0] instr,
                                             input imm_src_e    src);
    logic [31:0] imm;
    case (src)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 32x32 register file, x0 hardwired zero, write bypass
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   ra1, ra2        combinational read addresses
//   rd1, rd2        read data (0 for x0, ResultW when bypassing)
//   we, wa, wd      write-back port, sampled at the rising edge
module register_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wd
);

  logic [XLEN-1:0] mem [NREGS];
  logic            wr_en;

  assign wr_en = we && (wa != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        mem[i] <= '0;
      end
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  // A same-cycle write is forwarded so decode sees the value W is retiring.
  always_comb begin
    rd1 = mem[ra1];
    if (ra1 == '0) begin
      rd1 = '0;
    end else if (wr_en && (wa == ra1)) begin
      rd1 = wd;
    end
  end

  always_comb begin
    rd2 = mem[ra2];
    if (ra2 == '0) begin
      rd2 = '0;
    end else if (wr_en && (wa == ra2)) begin
      rd2 = wd;
    end
  end

endmodule

// File: rtl/decode_cycle.sv
// rtl/decode_cycle.sv - RV32I decode stage with register file and ID/EX register
//
// Inputs:  clk, rst (async active-high), InstrD/PCD/PCPlus4D from IF/ID,
//          RegWriteW/RDW/ResultW write-back port, FlushE bubble insert.
// Outputs: ID/EX register contents - controls (RegWriteE, ResultSrcE,
//          MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE), operands
//          (RD1E, RD2E, ImmExtE), register fields (RdE, Rs1E, Rs2E), PCE,
//          PCPlus4E.
// Option:  DECODE_ILLEGAL_FLAG_EN adds registered output IllegalE.
module decode_cycle
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     InstrD,
  input  logic [XLEN-1:0] PCD,
  input  logic [XLEN-1:0] PCPlus4D,
  input  logic            RegWriteW,
  input  logic [4:0]      RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic            FlushE,
  output logic            RegWriteE,
  output logic [1:0]      ResultSrcE,
  output logic            MemWriteE,
  output logic            JumpE,
  output logic            BranchE,
  output logic [2:0]      ALUControlE,
  output logic            ALUSrcE,
  output logic [XLEN-1:0] RD1E,
  output logic [XLEN-1:0] RD2E,
  output logic [XLEN-1:0] ImmExtE,
  output logic [4:0]      RdE,
  output logic [4:0]      Rs1E,
  output logic [4:0]      Rs2E,
  output logic [XLEN-1:0] PCE,
  output logic [XLEN-1:0] PCPlus4E
`ifdef DECODE_ILLEGAL_FLAG_EN
  ,
  output logic            IllegalE
`endif
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1_d;
  logic [4:0]      rs2_d;
  logic [4:0]      rd_d;
  logic [XLEN-1:0] rd1_d;
  logic [XLEN-1:0] rd2_d;
  logic [XLEN-1:0] imm_d;
  imm_src_e        imm_src;
  logic [1:0]      alu_op;
  ctrl_t           ctrl_d;
  ctrl_t           ctrl_e;

  assign opcode = InstrD[6:0];
  assign rd_d   = InstrD[11:7];
  assign funct3 = InstrD[14:12];
  assign rs1_d  = InstrD[19:15];
  assign rs2_d  = InstrD[24:20];

  register_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_regfile (
    .clk (clk),
    .rst (rst),
    .ra1 (rs1_d),
    .ra2 (rs2_d),
    .rd1 (rd1_d),
    .rd2 (rd2_d),
    .we  (RegWriteW),
    .wa  (RDW),
    .wd  (ResultW)
  );

  // Main decode; unsupported opcodes fall through as a NOP with an
  // I-format immediate so the value is still deterministic.
  always_comb begin
    ctrl_d  = CTRL_NOP;
    imm_src = IMM_I;
    alu_op  = 2'b00;
    case (opcode)
      OP_LW: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = 1'b1;
        ctrl_d.result_src = RES_MEM;
      end
      OP_SW: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        imm_src          = IMM_S;
      end
      OP_RTYPE: begin
        ctrl_d.reg_write = 1'b1;
        alu_op           = 2'b10;
      end
      OP_IALU: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.alu_src   = 1'b1;
        alu_op           = 2'b10;
      end
      OP_BEQ: begin
        ctrl_d.branch = 1'b1;
        alu_op        = 2'b01;
        imm_src       = IMM_B;
      end
      OP_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.jump       = 1'b1;
        ctrl_d.result_src = RES_PC4;
        imm_src           = IMM_J;
      end
      default: ;
    endcase

    case (alu_op)
      2'b00: ctrl_d.alu_control = ALU_ADD;
      2'b01: ctrl_d.alu_control = ALU_SUB;
      default: begin
        case (funct3)
          // funct7[5] means sub only for R-type; addi reuses that bit as imm.
          3'b000:  ctrl_d.alu_control = (opcode[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
          3'b010:  ctrl_d.alu_control = ALU_SLT;
          3'b110:  ctrl_d.alu_control = ALU_OR;
          3'b111:  ctrl_d.alu_control = ALU_AND;
          default: ctrl_d.alu_control = ALU_ADD;
        endcase
      end
    endcase
  end

  assign imm_d = imm_extend(InstrD, imm_src);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_e   <= CTRL_NOP;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      RdE      <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
    end else if (FlushE) begin
      ctrl_e   <= CTRL_NOP;
      RD1E     <= '0;
      RD2E     <= '0;
      ImmExtE  <= '0;
      RdE      <= '0;
      Rs1E     <= '0;
      Rs2E     <= '0;
      PCE      <= '0;
      PCPlus4E <= '0;
    end else begin
      ctrl_e   <= ctrl_d;
      RD1E     <= rd1_d;
      RD2E     <= rd2_d;
      ImmExtE  <= imm_d;
      RdE      <= rd_d;
      Rs1E     <= rs1_d;
      Rs2E     <= rs2_d;
      PCE      <= PCD;
      PCPlus4E <= PCPlus4D;
    end
  end

  assign RegWriteE   = ctrl_e.reg_write;
  assign ResultSrcE  = ctrl_e.result_src;
  assign MemWriteE   = ctrl_e.mem_write;
  assign JumpE       = ctrl_e.jump;
  assign BranchE     = ctrl_e.branch;
  assign ALUControlE = ctrl_e.alu_control;
  assign ALUSrcE     = ctrl_e.alu_src;

`ifdef DECODE_ILLEGAL_FLAG_EN
  logic illegal_d;

  always_comb begin
    illegal_d = 1'b0;
    case (opcode)
      OP_LW, OP_SW, OP_IALU, OP_BEQ, OP_JAL: illegal_d = 1'b0;
      OP_RTYPE: illegal_d = (InstrD[31:25] != 7'b0000000) &&
                            (InstrD[31:25] != 7'b0100000);
      default:  illegal_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      IllegalE <= 1'b0;
    end else if (FlushE) begin
      IllegalE <= 1'b0;
    end else begin
      IllegalE <= illegal_d;
    end
  end
`endif

endmodule
